// File: rtl/lc3b_types.sv
// Shared constants and types for the cache write-merge buffer.
package lc3b_types;

  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_WORD_BYTES = 2;
  localparam int DEF_ENTRIES    = 2;
  localparam int DEF_ADDR_W     = 16;

  // Drain FSM: IDLE looks for a reason to drain, DRAIN presents one entry.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/line_byte_merge.sv
// Word-into-line byte filter: overlays the enabled bytes of one word onto
// a line at the given word index and reports which line bytes were written.
module line_byte_merge #(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int IDX_W      = (LINE_BYTES > WORD_BYTES) ? $clog2(LINE_BYTES / WORD_BYTES) : 1
) (
  input  logic [8*LINE_BYTES-1:0] line,
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [IDX_W-1:0]        idx,
  output logic [8*LINE_BYTES-1:0] merged,
  output logic [LINE_BYTES-1:0]   mask_set
);

  // Replace each line byte that falls in the addressed word and is enabled.
  always_comb begin
    merged   = line;
    mask_set = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if ((b / WORD_BYTES) == int'(idx) && be[b % WORD_BYTES]) begin
        merged[8*b +: 8] = word[8*(b % WORD_BYTES) +: 8];
        mask_set[b]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_write_merge_buffer.sv
// Write-combining buffer: merges byte-enabled CPU word writes into line
// entries, drains them to the cache as masked line writes (oldest first),
// and forwards buffered bytes to reads.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. wr_ready does not depend on wr_valid. drain_valid, once raised,
// stays high with a stable payload until drain_ready is seen.
module cache_write_merge_buffer
  import lc3b_types::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int ENTRIES    = DEF_ENTRIES,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [8*WORD_BYTES-1:0]                wr_data,
  input  logic [WORD_BYTES-1:0]                  wr_be,
  input  logic [ADDR_W-1:0]                      rd_addr,
  output logic                                   rd_hit,
  output logic [8*WORD_BYTES-1:0]                rd_data,
  output logic [WORD_BYTES-1:0]                  rd_be,
  input  logic                                   flush,
  output logic                                   flush_done,
  output logic                                   drain_valid,
  input  logic                                   drain_ready,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   drain_tag,
  output logic [8*LINE_BYTES-1:0]                drain_data,
  output logic [LINE_BYTES-1:0]                  drain_mask,
  output logic                                   empty,
  output drain_state_e                           drain_state
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int WOFF_W = $clog2(WORD_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int IDX_W  = (LINE_BYTES > WORD_BYTES) ? $clog2(LINE_BYTES / WORD_BYTES) : 1;
  localparam int SEL_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W  = $clog2(ENTRIES + 1);
  localparam int LINE_W = 8 * LINE_BYTES;

  // Entry storage; age 0 is the oldest valid entry.
  logic [ENTRIES-1:0]    ent_valid;
  logic [TAG_W-1:0]      ent_tag  [ENTRIES];
  logic [LINE_W-1:0]     ent_data [ENTRIES];
  logic [LINE_BYTES-1:0] ent_mask [ENTRIES];
  logic [SEL_W-1:0]      ent_age  [ENTRIES];

  drain_state_e     state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic             flush_pending;

  logic [TAG_W-1:0] wr_tag, rd_tag;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_hit, free_ok, full_any, old_found;
  logic [SEL_W-1:0] wr_hit_idx, free_idx, old_idx, tgt_idx, alloc_age;
  logic [CNT_W-1:0] valid_cnt;
  logic             drain_fire, wr_fire;
  logic [LINE_W-1:0]     merge_base, merged_line;
  logic [LINE_BYTES-1:0] mask_set;
  logic [LINE_W-1:0]     rd_line;
  logic [LINE_BYTES-1:0] rd_mask;

  assign wr_tag = wr_addr[ADDR_W-1:OFF_W];
  assign rd_tag = rd_addr[ADDR_W-1:OFF_W];
  assign wr_idx = IDX_W'(wr_addr[OFF_W-1:0] >> WOFF_W);
  assign rd_idx = IDX_W'(rd_addr[OFF_W-1:0] >> WOFF_W);

  generate
    if (WOFF_W > 0) begin : g_unused_low
      logic unused_low;
      assign unused_low = ^{wr_addr[WOFF_W-1:0], rd_addr[WOFF_W-1:0]};
    end
  endgenerate

  // Tag lookup, free-slot search, oldest-entry search and occupancy.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_ok    = 1'b0;
    free_idx   = '0;
    full_any   = 1'b0;
    old_found  = 1'b0;
    old_idx    = '0;
    valid_cnt  = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      valid_cnt = valid_cnt + CNT_W'(ent_valid[e]);
      if (ent_valid[e] && !wr_hit && ent_tag[e] == wr_tag) begin
        wr_hit     = 1'b1;
        wr_hit_idx = SEL_W'(e);
      end
      if (!ent_valid[e] && !free_ok) begin
        free_ok  = 1'b1;
        free_idx = SEL_W'(e);
      end
      if (ent_valid[e] && (&ent_mask[e])) full_any = 1'b1;
      if (ent_valid[e] && (!old_found || ent_age[e] < ent_age[old_idx])) begin
        old_found = 1'b1;
        old_idx   = SEL_W'(e);
      end
    end
  end

  assign drain_fire = (state == ST_DRAIN) && drain_ready;
  assign wr_ready   = !flush_pending &&
                      (wr_hit ? !((state == ST_DRAIN) && (wr_hit_idx == sel)) : free_ok);
  assign wr_fire    = wr_valid && wr_ready;
  assign tgt_idx    = wr_hit ? wr_hit_idx : free_idx;
  // A new entry is youngest; if an older entry leaves this same cycle it
  // takes the post-drain position.
  assign alloc_age  = SEL_W'(valid_cnt) - SEL_W'(drain_fire);
  assign merge_base = wr_hit ? ent_data[wr_hit_idx] : '0;

  line_byte_merge #(
    .LINE_BYTES (LINE_BYTES),
    .WORD_BYTES (WORD_BYTES),
    .IDX_W      (IDX_W)
  ) u_merge (
    .line     (merge_base),
    .word     (wr_data),
    .be       (wr_be),
    .idx      (wr_idx),
    .merged   (merged_line),
    .mask_set (mask_set)
  );

  // Entry update: free and re-age on drain, merge or allocate on write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        ent_tag[e]  <= '0;
        ent_data[e] <= '0;
        ent_mask[e] <= '0;
        ent_age[e]  <= '0;
      end
    end else begin
      if (drain_fire) begin
        ent_valid[sel] <= 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
          if (ent_valid[e] && ent_age[e] > ent_age[sel]) ent_age[e] <= ent_age[e] - 1'b1;
        end
      end
      if (wr_fire) begin
        ent_valid[tgt_idx] <= 1'b1;
        ent_tag[tgt_idx]   <= wr_tag;
        ent_data[tgt_idx]  <= merged_line;
        ent_mask[tgt_idx]  <= (wr_hit ? ent_mask[wr_hit_idx] : '0) | mask_set;
        if (!wr_hit) ent_age[tgt_idx] <= alloc_age;
      end
    end
  end

  // Drain FSM state and selected entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Drain FSM next state: start on a full line, full buffer or pending flush.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      ST_IDLE: begin
        if (old_found && (full_any || (&ent_valid) || flush_pending)) begin
          state_nxt = ST_DRAIN;
          sel_nxt   = old_idx;
        end
      end
      ST_DRAIN: begin
        if (drain_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flush tracking: set by a pulse, cleared once the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending <= 1'b0;
    end else if (flush_pending && empty) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end
  end

  assign empty       = ~|ent_valid;
  assign flush_done  = flush_pending && empty;
  assign drain_valid = (state == ST_DRAIN);
  assign drain_tag   = ent_tag[sel];
  assign drain_data  = ent_data[sel];
  assign drain_mask  = ent_mask[sel];
  assign drain_state = state;

  // Read forwarding from registered entry state only.
  always_comb begin
    rd_hit  = 1'b0;
    rd_line = '0;
    rd_mask = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (!rd_hit && ent_valid[e] && ent_tag[e] == rd_tag) begin
        rd_hit  = 1'b1;
        rd_line = ent_data[e];
        rd_mask = ent_mask[e];
      end
    end
    rd_data = '0;
    rd_be   = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (rd_mask[int'(rd_idx) * WORD_BYTES + k]) begin
        rd_be[k]         = 1'b1;
        rd_data[8*k +: 8] = rd_line[8*(int'(rd_idx) * WORD_BYTES + k) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cache_write_merge_buffer.sv
// Directed bench for cache_write_merge_buffer with default parameters.
module tb_cache_write_merge_buffer;
  import lc3b_types::*;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_be;
  logic [15:0]   rd_addr;
  logic          rd_hit;
  logic [15:0]   rd_data;
  logic [1:0]    rd_be;
  logic          flush;
  logic          flush_done;
  logic          drain_valid;
  logic          drain_ready;
  logic [11:0]   drain_tag;
  logic [127:0]  drain_data;
  logic [15:0]   drain_mask;
  logic          empty;
  drain_state_e  drain_state;

  int n_assert = 0;
  int n_fail   = 0;

  cache_write_merge_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .rd_addr     (rd_addr),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .rd_be       (rd_be),
    .flush       (flush),
    .flush_done  (flush_done),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_tag   (drain_tag),
    .drain_data  (drain_data),
    .drain_mask  (drain_mask),
    .empty       (empty),
    .drain_state (drain_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds a write until accepted; tries counts cycles presented.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                          output int tries);
    logic done;
    done     = 1'b0;
    tries    = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    while (!done && tries < 20) begin
      #1;
      tries++;
      if (wr_ready === 1'b1) done = 1'b1;
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output int cyc);
    cyc = 0;
    while (drain_valid !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int t;
    int c;
    logic [127:0] exp_line;

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr = '0; flush = 1'b0; drain_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_rd_hit", rd_hit, 0);
    chk("rst_state", drain_state, ST_IDLE);

    // Two partial writes into line 0x010, then flush.
    do_write(16'h0106, 16'h1234, 2'b11, t);
    chk("t1_w0_tries", t, 1);
    do_write(16'h0108, 16'h00AB, 2'b01, t);
    chk("t1_w1_tries", t, 1);
    rd_addr = 16'h0106; #1;
    chk("t1_rd_hit", rd_hit, 1);
    chk("t1_rd_data", rd_data, 16'h1234);
    chk("t1_rd_be", rd_be, 2'b11);
    chk("t1_no_drain", drain_valid, 0);
    drain_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t1_flush_done_early", flush_done, 0);
    wait_drain(10, c);
    chk("t1_drain_lat", c, 1);
    chk("t1_tag", drain_tag, 12'h010);
    chk("t1_mask", drain_mask, 16'h01C0);
    chk("t1_data", drain_data, 128'h00000000_000000AB_12340000_00000000);
    step();
    chk("t1_drain_off", drain_valid, 0);
    chk("t1_empty", empty, 1);
    chk("t1_flush_done", flush_done, 1);
    step();
    chk("t1_flush_done_pulse", flush_done, 0);
    chk("t1_still_idle", drain_valid, 0);

    // Fill line 0x020 completely; drains without flush.
    drain_ready = 1'b0;
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      do_write(16'h0200 + 16'(2 * i), 16'h1100 + 16'(i), 2'b11, t);
      chk("t2_w_tries", t, 1);
      exp_line[16*i +: 16] = 16'h1100 + 16'(i);
    end
    wait_drain(10, c);
    chk("t2_drain_lat", c, 1);
    chk("t2_tag", drain_tag, 12'h020);
    chk("t2_mask", drain_mask, 16'hFFFF);
    chk("t2_data", drain_data, exp_line);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    chk("t2_empty", empty, 1);
    chk("t2_drain_off", drain_valid, 0);

    // Two lines fill the buffer; third line must wait for a free entry.
    do_write(16'h0300, 16'h5566, 2'b11, t);
    chk("t3_w0_tries", t, 1);
    do_write(16'h0400, 16'h7788, 2'b11, t);
    chk("t3_w1_tries", t, 1);
    wait_drain(10, c);
    chk("t3_drain_lat", c, 1);
    chk("t3_tag", drain_tag, 12'h030);
    chk("t3_mask", drain_mask, 16'h0003);
    chk("t3_data", drain_data, 128'h5566);
    wr_valid = 1'b1; wr_addr = 16'h0500; wr_data = 16'hCAFE; wr_be = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall", wr_ready, 0);
      step();
    end
    wr_valid = 1'b0;
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    chk("t3_freed", drain_valid, 0);
    do_write(16'h0500, 16'hCAFE, 2'b11, t);
    chk("t3_w2_tries", t, 1);
    wait_drain(10, c);
    chk("t3_drain2_lat", c, 1);
    chk("t3_oldest_tag", drain_tag, 12'h040);
    chk("t3_oldest_data", drain_data, 128'h7788);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t3_rst_empty", empty, 1);
    chk("t3_rst_drain", drain_valid, 0);

    // Flush while already empty.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flush_done", flush_done, 1);
    step();
    chk("t4_flush_done_pulse", flush_done, 0);

    // Read forwarding and zero byte-enable writes.
    do_write(16'h0310, 16'hBEEF, 2'b10, t);
    chk("t5_w0_tries", t, 1);
    rd_addr = 16'h0310; #1;
    chk("t5_rd_hit", rd_hit, 1);
    chk("t5_rd_be", rd_be, 2'b10);
    chk("t5_rd_data", rd_data, 16'hBE00);
    rd_addr = 16'h0320; #1;
    chk("t5_miss_hit", rd_hit, 0);
    chk("t5_miss_be", rd_be, 2'b00);
    chk("t5_miss_data", rd_data, 16'h0000);
    do_write(16'h0312, 16'hFFFF, 2'b00, t);
    chk("t5_be0_tries", t, 1);
    rd_addr = 16'h0312; #1;
    chk("t5_be0_hit", rd_hit, 1);
    chk("t5_be0_be", rd_be, 2'b00);
    chk("t5_be0_data", rd_data, 16'h0000);
    do_write(16'h0330, 16'h1111, 2'b00, t);
    chk("t5_alloc0_tries", t, 1);
    rd_addr = 16'h0330; #1;
    chk("t5_alloc0_hit", rd_hit, 1);
    chk("t5_alloc0_be", rd_be, 2'b00);

    // Held drain: stable payload, same-line write stalled.
    wait_drain(10, c);
    chk("t6_drain_lat", c, 1);
    wr_valid = 1'b1; wr_addr = 16'h0314; wr_data = 16'h9999; wr_be = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_stall", wr_ready, 0);
      chk("t6_valid", drain_valid, 1);
      chk("t6_state", drain_state, ST_DRAIN);
      chk("t6_tag", drain_tag, 12'h031);
      chk("t6_mask", drain_mask, 16'h0002);
      chk("t6_data", drain_data, 128'hBE00);
      step();
    end
    wr_valid = 1'b0;
    do_write(16'h0332, 16'h4455, 2'b11, t);
    chk("t6_other_tries", t, 1);
    rd_addr = 16'h0332; #1;
    chk("t6_other_hit", rd_hit, 1);
    chk("t6_other_data", rd_data, 16'h4455);
    chk("t6_other_be", rd_be, 2'b11);
    chk("t6_still_held", drain_valid, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_addr = 16'h0310; #1;
    chk("t6_rst_drain", drain_valid, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_wr_ready", wr_ready, 1);
    chk("t6_rst_rd_hit", rd_hit, 0);
    chk("t6_rst_state", drain_state, ST_IDLE);
    chk("t6_rst_flush_done", flush_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
